// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
//   Shared constants and helpers for the video path.
//
//   MATRIX_LATENCY : clocks from a pixel entering matrix_3x3_gen to it
//                    appearing as the newest element (2,2) of a window.
//                    The sync-delay stage uses this as its DLY_CNT.
//   clog2()        : ceil(log2(n)), never below 1, so the result can size a
//                    counter or an address bus directly.
//   win_idx()      : flat element index of window position (r,c).
// -----------------------------------------------------------------------------
package video_pkg;

    localparam int MATRIX_LATENCY = 2;

    localparam int WIN_ROWS = 3;
    localparam int WIN_COLS = 3;

    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

    function automatic int win_idx(input int r, input int c);
        return WIN_COLS * r + c;
    endfunction

endpackage : video_pkg

// File: rtl/line_buf_ram.sv
// -----------------------------------------------------------------------------
// line_buf_ram
//   Simple dual-port line buffer, one write port and one read port, both
//   synchronous to sclk. Read-before-write: a read and a write to the same
//   address in the same cycle return the old contents. The read register
//   holds its value while rd_en is low, so downstream logic may consume the
//   data on any later cycle up to the next read.
//
//   Ports
//     sclk     in   clock
//     wr_en    in   write enable
//     wr_addr  in   write address
//     wr_data  in   write data
//     rd_en    in   read enable
//     rd_addr  in   read address
//     rd_data  out  registered read data
// -----------------------------------------------------------------------------
module line_buf_ram
    import video_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 640,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              sclk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    // NOTE: the storage array has no reset; a reset port would stop it mapping
    // onto block RAM, and stale contents are masked by the window gating.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge sclk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule : line_buf_ram

// File: rtl/matrix_3x3_gen.sv
// -----------------------------------------------------------------------------
// matrix_3x3_gen
//   Streaming 3x3 window generator. Consumes a raster pixel stream and emits
//   the 3x3 neighbourhood of every interior pixel (row>=2, col>=2 of the
//   newest pixel). Fixed latency of MATRIX_LATENCY clocks, no backpressure.
//
//   Ports
//     sclk      in   clock, all logic on the rising edge
//     s_rst     in   synchronous active-high reset
//     pi_vsync  in   frame sync, rising edge restarts counting at (0,0)
//     pi_de     in   pixel valid
//     pi_data   in   pixel value
//     po_de     out  window valid
//     po_win    out  3x3 window, element (r,c) at [DATA_W*(3r+c) +: DATA_W];
//                    r=0 oldest row, c=0 oldest column, (2,2) newest pixel
//     po_row    out  input row of the (2,2) pixel
// -----------------------------------------------------------------------------
module matrix_3x3_gen
    import video_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic                      sclk,
    input  logic                      s_rst,
    input  logic                      pi_vsync,
    input  logic                      pi_de,
    input  logic [DATA_W-1:0]         pi_data,
    output logic                      po_de,
    output logic [9*DATA_W-1:0]       po_win,
    output logic [clog2(IMG_H)-1:0]   po_row
);

    localparam int COL_W = clog2(IMG_W);
    localparam int ROW_W = clog2(IMG_H);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    typedef logic [DATA_W-1:0] pix_t;

    // -------------------------------------------------------------------------
    // Position counters and vsync edge detect
    // -------------------------------------------------------------------------
    logic             vsync_q;
    logic             vs_rise;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_row;

    assign vs_rise = pi_vsync & ~vsync_q;

    // Coordinate of the pixel on the bus this cycle. A vsync edge in the same
    // cycle as a pixel makes that pixel (0,0).
    assign cur_col = vs_rise ? '0 : col;
    assign cur_row = vs_rise ? '0 : row;

    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // register in the design samples values from before the clock edge.
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            vsync_q <= 1'b0;
            col     <= '0;
            row     <= '0;
        end else begin
            vsync_q <= pi_vsync;
            if (pi_de) begin
                if (cur_col == COL_LAST) begin
                    col <= '0;
                    row <= (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
                end else begin
                    col <= cur_col + COL_W'(1);
                    row <= cur_row;
                end
            end else if (vs_rise) begin
                col <= '0;
                row <= '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Line buffers
    //   lb0 holds the previous line: read and written at the current column.
    //   lb1 holds the line before that: it is fed with lb0's read data one
    //   cycle later, at the column captured in stage 1, so its read at the
    //   current column returns row-2.
    // -------------------------------------------------------------------------
    pix_t             lb0_rd;
    pix_t             lb1_rd;
    logic             s1_de;
    logic [COL_W-1:0] s1_col;
    logic [ROW_W-1:0] s1_row;
    pix_t             s1_data;

    line_buf_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W),
        .ADDR_W (COL_W)
    ) u_lb0 (
        .sclk    (sclk),
        .wr_en   (pi_de),
        .wr_addr (cur_col),
        .wr_data (pi_data),
        .rd_en   (pi_de),
        .rd_addr (cur_col),
        .rd_data (lb0_rd)
    );

    line_buf_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W),
        .ADDR_W (COL_W)
    ) u_lb1 (
        .sclk    (sclk),
        .wr_en   (s1_de),
        .wr_addr (s1_col),
        .wr_data (lb0_rd),
        .rd_en   (pi_de),
        .rd_addr (cur_col),
        .rd_data (lb1_rd)
    );

    // -------------------------------------------------------------------------
    // Stage 1: capture the pixel and its position alongside the line-buffer
    // read registers, so all three rows of the new column line up.
    // -------------------------------------------------------------------------
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            s1_de   <= 1'b0;
            s1_col  <= '0;
            s1_row  <= '0;
            s1_data <= '0;
        end else begin
            s1_de <= pi_de;
            if (pi_de) begin
                s1_col  <= cur_col;
                s1_row  <= cur_row;
                s1_data <= pi_data;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: window shift register. win_shift is the window after the new
    // column is shifted in; it feeds both the shift register and po_win so
    // the output carries no extra cycle of latency.
    // -------------------------------------------------------------------------
    pix_t               win_q     [WIN_ROWS][WIN_COLS];
    pix_t               win_shift [WIN_ROWS][WIN_COLS];
    logic [9*DATA_W-1:0] win_flat;
    logic               s1_inner;

    // NOTE: every element is assigned on every pass, so no latch is inferred.
    always_comb begin
        for (int r = 0; r < WIN_ROWS; r++) begin
            win_shift[r][0] = win_q[r][1];
            win_shift[r][1] = win_q[r][2];
        end
        win_shift[0][2] = lb1_rd;
        win_shift[1][2] = lb0_rd;
        win_shift[2][2] = s1_data;
    end

    always_comb begin
        win_flat = '0;
        for (int r = 0; r < WIN_ROWS; r++) begin
            for (int c = 0; c < WIN_COLS; c++) begin
                win_flat[DATA_W*win_idx(r, c) +: DATA_W] = win_shift[r][c];
            end
        end
    end

    // Only windows fully inside the frame are valid: three complete rows and
    // three columns of the current line. This also hides stale line-buffer
    // data and prevents mixing the end of one line with the start of the next.
    assign s1_inner = (32'(s1_row) >= 2) && (32'(s1_col) >= 2);

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            for (int r = 0; r < WIN_ROWS; r++) begin
                for (int c = 0; c < WIN_COLS; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            po_de  <= 1'b0;
            po_win <= '0;
            po_row <= '0;
        end else begin
            if (s1_de) begin
                win_q <= win_shift;
            end
            po_de <= s1_de & s1_inner;
            if (s1_de && s1_inner) begin
                po_win <= win_flat;
                po_row <= s1_row;
            end
        end
    end

endmodule : matrix_3x3_gen
